// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// Parametrised synchronous FIFO with a true occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// build-time choice of first-word-fall-through or registered-read output.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   wr_i            write request
//   rd_i            read request (acknowledge of the displayed word when FWFT=1)
//   w_data_i        write data
//   clr_err_i       clears the sticky overflow/underflow flags
//   r_data_o        read data
//   r_valid_o       r_data_o holds a valid word
//   empty_o         count == 0
//   full_o          count == DEPTH
//   almost_empty_o  count <= AE_LEVEL
//   almost_full_o   count >= AF_LEVEL
//   count_o         occupancy, 0..DEPTH
//   overflow_o      sticky: a write was dropped
//   underflow_o     sticky: a read was refused
module sync_fifo_flags #(
    parameter int D_WIDTH  = 8,
    parameter int A_WIDTH  = 4,
    parameter int AF_LEVEL = 2**A_WIDTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_i,
    input  logic               rd_i,
    input  logic [D_WIDTH-1:0] w_data_i,
    input  logic               clr_err_i,
    output logic [D_WIDTH-1:0] r_data_o,
    output logic               r_valid_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               almost_empty_o,
    output logic               almost_full_o,
    output logic [A_WIDTH:0]   count_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int DEPTH = 2**A_WIDTH;
    localparam logic [A_WIDTH:0] DEPTH_CNT = (A_WIDTH+1)'(DEPTH);
    localparam logic [A_WIDTH:0] AF_CNT    = (A_WIDTH+1)'(AF_LEVEL);
    localparam logic [A_WIDTH:0] AE_CNT    = (A_WIDTH+1)'(AE_LEVEL);

    // Threshold parameters outside the legal range would give flags that can
    // never (or always) assert, so refuse to build.
    generate
        if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_badLevels
            $error("sync_fifo_flags: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
        end
    endgenerate

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [A_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [A_WIDTH:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               wrOk;
    logic               rdOk;

    // A write into a full FIFO is still accepted when a read frees the slot on
    // the same edge; the read sees the old word because memory updates late.
    assign rdOk = rd_i & (count_q != '0);
    assign wrOk = wr_i & ((count_q != DEPTH_CNT) | rdOk);

    // Next-state for pointers, occupancy and sticky errors. A new error on the
    // same edge as clr_err_i wins so no event is ever lost.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q & ~clr_err_i) | (wr_i & ~wrOk);
        underflow_d = (underflow_q & ~clr_err_i) | (rd_i & ~rdOk);
        if (wrOk) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdOk) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({wrOk, rdOk})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset overrides any transfer on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && wrOk) begin
            mem[wrPtr_q] <= w_data_i;
        end
    end

    // Read-side output path: either the head word shown directly, or a
    // registered copy taken on each accepted read.
    generate
        if (FWFT) begin : g_fwft
            assign r_data_o  = mem[rdPtr_q];
            assign r_valid_o = (count_q != '0);
        end else begin : g_regRead
            logic [D_WIDTH-1:0] rData_q;
            logic               rValid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rData_q  <= '0;
                    rValid_q <= 1'b0;
                end else begin
                    rValid_q <= rdOk;
                    if (rdOk) begin
                        rData_q <= mem[rdPtr_q];
                    end
                end
            end

            assign r_data_o  = rData_q;
            assign r_valid_o = rValid_q;
        end
    endgenerate

    assign count_o        = count_q;
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == DEPTH_CNT);
    assign almost_empty_o = (count_q <= AE_CNT);
    assign almost_full_o  = (count_q >= AF_CNT);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags
// Drives one FWFT and one registered-read instance of sync_fifo_flags with the
// same inputs and compares both against a queue-based reference model after
// every clock edge, plus directed constant checks on the headline scenarios.
module tb_sync_fifo_flags;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] wData = 8'h00;
    logic       clrErr = 1'b0;

    logic [7:0] fRData, rRData;
    logic       fRValid, rRValid;
    logic       fEmpty, rEmpty, fFull, rFull;
    logic       fAe, rAe, fAf, rAf;
    logic [4:0] fCount, rCount;
    logic       fOvf, rOvf, fUnf, rUnf;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // Reference model: the FIFO contents as a queue plus the error flags and
    // the registered-read output register.
    logic [7:0] q [$];
    logic       mOvf = 1'b0;
    logic       mUnf = 1'b0;
    logic       mRegValid = 1'b0;
    logic [7:0] mRegData = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .D_WIDTH(8), .A_WIDTH(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)
    ) dutF (
        .clk(clk), .rst(rst), .wr_i(wr), .rd_i(rd), .w_data_i(wData),
        .clr_err_i(clrErr), .r_data_o(fRData), .r_valid_o(fRValid),
        .empty_o(fEmpty), .full_o(fFull), .almost_empty_o(fAe),
        .almost_full_o(fAf), .count_o(fCount), .overflow_o(fOvf),
        .underflow_o(fUnf)
    );

    sync_fifo_flags #(
        .D_WIDTH(8), .A_WIDTH(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)
    ) dutR (
        .clk(clk), .rst(rst), .wr_i(wr), .rd_i(rd), .w_data_i(wData),
        .clr_err_i(clrErr), .r_data_o(rRData), .r_valid_o(rRValid),
        .empty_o(rEmpty), .full_o(rFull), .almost_empty_o(rAe),
        .almost_full_o(rAf), .count_o(rCount), .overflow_o(rOvf),
        .underflow_o(rUnf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (%s): observed %0h expected %0h", tag, phase, obs, exp);
        end
    endtask

    // Compares every output of both instances against the model.
    task automatic checkOutput();
        int n;
        n = q.size();
        chk("F.count", fCount, n);
        chk("R.count", rCount, n);
        chk("F.empty", fEmpty, n == 0);
        chk("R.empty", rEmpty, n == 0);
        chk("F.full", fFull, n == DEPTH);
        chk("R.full", rFull, n == DEPTH);
        chk("F.almostEmpty", fAe, n <= AE);
        chk("R.almostEmpty", rAe, n <= AE);
        chk("F.almostFull", fAf, n >= AF);
        chk("R.almostFull", rAf, n >= AF);
        chk("F.overflow", fOvf, mOvf);
        chk("R.overflow", rOvf, mOvf);
        chk("F.underflow", fUnf, mUnf);
        chk("R.underflow", rUnf, mUnf);
        chk("F.rValid", fRValid, n != 0);
        if (n != 0) chk("F.rData", fRData, q[0]);
        chk("R.rValid", rRValid, mRegValid);
        chk("R.rData", rRData, mRegData);
    endtask

    // Drives one cycle of inputs, advances the model on the same edge and
    // checks the outputs shortly after the edge.
    task automatic applyStimulus(input logic r, input logic w, input logic rq,
                                 input logic [7:0] d, input logic c);
        logic rdAcc, wrAcc;
        rst = r; wr = w; rd = rq; wData = d; clrErr = c;
        @(posedge clk);
        if (r) begin
            q.delete();
            mOvf = 1'b0; mUnf = 1'b0; mRegValid = 1'b0; mRegData = 8'h00;
        end else begin
            rdAcc = rq && (q.size() > 0);
            wrAcc = w && ((q.size() < DEPTH) || rdAcc);
            mOvf = (mOvf && !c) || (w && !wrAcc);
            mUnf = (mUnf && !c) || (rq && !rdAcc);
            mRegValid = rdAcc;
            if (rdAcc) mRegData = q.pop_front();
            if (wrAcc) q.push_back(d);
        end
        #1;
        checkOutput();
    endtask

    task automatic idle();            applyStimulus(0, 0, 0, 8'h00, 0); endtask
    task automatic push(input logic [7:0] d); applyStimulus(0, 1, 0, d, 0); endtask
    task automatic pop();             applyStimulus(0, 0, 1, 8'h00, 0); endtask

    initial begin
        $display("[TB] start");

        phase = "reset";
        applyStimulus(1, 0, 0, 8'h00, 0);
        applyStimulus(1, 0, 0, 8'h00, 0);
        idle();
        idle();
        chk("t1 count", fCount, 0);
        chk("t1 almostFull", fAf, 0);
        chk("t1 rValid", rRValid, 0);

        phase = "fill";
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            if (i == 1) chk("t2 aeAfter2", fAe, 1);
            if (i == 2) chk("t2 aeAfter3", fAe, 0);
            if (i == 12) chk("t2 afAfter13", fAf, 0);
            if (i == 13) chk("t2 afAfter14", fAf, 1);
        end
        chk("t2 full", fFull, 1);
        chk("t2 count16", rCount, 16);
        push(8'hAA);
        chk("t2 overflow", fOvf, 1);
        chk("t2 countHeld", fCount, 16);

        phase = "drain";
        for (int i = 0; i < 16; i++) begin
            chk("t2 headWord", fRData, i);
            pop();
            chk("t2 regWord", rRData, i);
        end
        chk("t2 emptyAfter", fEmpty, 1);
        applyStimulus(0, 0, 0, 8'h00, 1);

        phase = "emptyRdWr";
        applyStimulus(0, 1, 1, 8'h5C, 0);
        chk("t3 count", fCount, 1);
        chk("t3 underflow", fUnf, 1);
        chk("t3 rData", fRData, 8'h5C);
        chk("t3 rValid", fRValid, 1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        chk("t3 clrErr", fUnf, 0);
        pop();

        phase = "fullRdWr";
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t4 headBefore", fRData, 8'h00);
        applyStimulus(0, 1, 1, 8'h77, 0);
        chk("t4 regWord", rRData, 8'h00);
        chk("t4 count", fCount, 16);
        chk("t4 noOverflow", fOvf, 0);
        for (int i = 1; i < 17; i++) begin
            pop();
            chk("t4 wrapWord", rRData, (i == 16) ? 8'h77 : 8'(i));
        end

        phase = "regRead";
        push(8'h11);
        push(8'h22);
        pop();
        chk("t5 valid", rRValid, 1);
        chk("t5 data", rRData, 8'h11);
        idle();
        chk("t5 validDrop", rRValid, 0);
        chk("t5 dataHeld", rRData, 8'h11);
        push(8'h33);
        pop();
        chk("t5 b2b1", rRData, 8'h22);
        pop();
        chk("t5 b2b2", rRData, 8'h33);
        chk("t5 b2bValid", rRValid, 1);

        phase = "midReset";
        for (int i = 0; i < 7; i++) push(8'(8'h40 + i));
        chk("t6 count7", fCount, 7);
        applyStimulus(1, 1, 1, 8'h99, 0);
        chk("t6 countReset", fCount, 0);
        chk("t6 emptyReset", rEmpty, 1);
        push(8'h3E);
        chk("t6 head", fRData, 8'h3E);
        pop();
        chk("t6 regWord", rRData, 8'h3E);

        phase = "random";
        for (int i = 0; i < 900; i++) begin
            int wrP;
            logic r, w, rq, c;
            case ((i / 100) % 3)
                0:       wrP = 80;
                1:       wrP = 20;
                default: wrP = 50;
            endcase
            w  = ($urandom_range(99) < wrP);
            rq = ($urandom_range(99) < (100 - wrP));
            c  = ($urandom_range(19) == 0);
            r  = ($urandom_range(249) == 0);
            applyStimulus(r, w, rq, 8'($urandom), c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
